// File: rtl/adder_resp.sv
// adder_resp: clocked adder responder with a small result FIFO.
//
// Accepts operand pairs over a valid/ready handshake. Each accepted pair is
// summed with carry-out, tagged with an 8-bit sequence number and queued.
// Results leave in acceptance order over a second valid/ready handshake.
//
// Parameters
//   WIDTH  operand width in bits
//   DEPTH  result FIFO entries (power of two, 2..16)
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   in_valid_i   in   operand pair present
//   in_ready_o   out  block can accept an operand pair this cycle
//   a_i, b_i     in   operands (WIDTH bits)
//   out_valid_o  out  head result valid
//   out_ready_i  in   consumer takes the head result this cycle
//   s_o          out  sum modulo 2^WIDTH
//   c_o          out  carry-out
//   seq_o        out  sequence tag of the head result
//   count_o      out  FIFO occupancy
module adder_resp #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           s_o,
  output logic                       c_o,
  output logic [7:0]                 seq_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

  // Sum with carry in the MSB: {c, s}.
  function automatic logic [WIDTH:0] f_add(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Result storage is not reset; the outputs are masked while empty instead.
  logic [WIDTH:0]  r_sum_mem [DEPTH];
  logic [7:0]      r_seq_mem [DEPTH];

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_seq;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [WIDTH:0]  w_sum;
  logic [WIDTH:0]  w_head_sum;
  logic [7:0]      w_head_seq;

  // Handshake readiness depends on registered occupancy only, so there is
  // no combinational path from out_ready_i to in_ready_o.
  assign w_in_ready  = (r_count < L_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid_i  && w_in_ready;
  assign w_pop       = out_ready_i && w_out_valid;
  assign w_sum       = f_add(a_i, b_i);

  // Storage write stage
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_sum_mem[r_wptr] <= w_sum;
      r_seq_mem[r_wptr] <= r_seq;
    end
  end

  // Control stage: pointers, occupancy, sequence counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_seq   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_seq  <= r_seq + 8'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry read; forced to zero while empty so reset shows clean outputs.
  assign w_head_sum = w_out_valid ? r_sum_mem[r_rptr] : '0;
  assign w_head_seq = w_out_valid ? r_seq_mem[r_rptr] : '0;

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign s_o         = w_head_sum[WIDTH-1:0];
  assign c_o         = w_head_sum[WIDTH];
  assign seq_o       = w_head_seq;
  assign count_o     = r_count;

endmodule

// File: tb/tb_adder_resp.sv
module tb_adder_resp;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] s_o;
  logic             c_o;
  logic [7:0]       seq_o;
  logic [CW-1:0]    count_o;

  adder_resp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .s_o         (s_o),
    .c_o         (c_o),
    .seq_o       (seq_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: an ordered list of pending results plus the next tag.
  typedef struct {
    int s;
    int c;
    int seq;
  } res_t;
  res_t m_q[$];
  int   m_seq;

  // Observed pops (value and tag at the moment the consumer takes them).
  int   pop_s[$];
  int   pop_seq[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_count"}, int'(count_o), m_q.size());
    chk({tag, "_ovalid"}, int'(out_valid_o), int'(m_q.size() != 0));
    chk({tag, "_iready"}, int'(in_ready_o), int'(m_q.size() < DEPTH));
    if (m_q.size() != 0) begin
      chk({tag, "_s"}, int'(s_o), m_q[0].s);
      chk({tag, "_c"}, int'(c_o), m_q[0].c);
      chk({tag, "_seq"}, int'(seq_o), m_q[0].seq);
    end else begin
      chk({tag, "_s0"}, int'(s_o), 0);
      chk({tag, "_c0"}, int'(c_o), 0);
      chk({tag, "_seq0"}, int'(seq_o), 0);
    end
  endtask

  // One clock edge: the model decides push/pop from its own occupancy and
  // the inputs currently applied, then the DUT outputs are compared #1 later.
  task automatic tick();
    bit push, pop;
    int sum;
    push = in_valid_i && (m_q.size() < DEPTH);
    pop  = out_ready_i && (m_q.size() != 0);
    if (out_valid_o && out_ready_i) begin
      pop_s.push_back(int'(s_o));
      pop_seq.push_back(int'(seq_o));
    end
    @(posedge clk_i);
    #1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      sum = int'(a_i) + int'(b_i);
      m_q.push_back('{sum % (1 << WIDTH), sum / (1 << WIDTH), m_seq});
      m_seq = (m_seq + 1) % 256;
    end
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = '0;
    b_i         = '0;
    #2;
    m_q.delete();
    m_seq = 0;
    pop_s.delete();
    pop_seq.delete();
    check_outputs("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drive(input int a, input int b);
    a_i        = WIDTH'(a);
    b_i        = WIDTH'(b);
    in_valid_i = 1'b1;
  endtask

  initial begin
    int ca[3];
    int cb[3];
    int cs[3];
    int cc[3];
    bit accepted;

    // Single transaction
    do_reset();
    drive(3, 5);
    tick();
    in_valid_i = 1'b0;
    chk("t1_valid", int'(out_valid_o), 1);
    chk("t1_s", int'(s_o), 8);
    chk("t1_c", int'(c_o), 0);
    chk("t1_seq", int'(seq_o), 0);
    out_ready_i = 1'b1;
    tick();
    chk("t1_pop_valid", int'(out_valid_o), 0);
    chk("t1_pop_count", int'(count_o), 0);

    // Carry cases
    ca = '{15, 15, 0}; cb = '{1, 15, 0};
    cs = '{0, 14, 0};  cc = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      drive(ca[i], cb[i]);
      out_ready_i = 1'b0;
      tick();
      in_valid_i = 1'b0;
      chk("carry_s", int'(s_o), cs[i]);
      chk("carry_c", int'(c_o), cc[i]);
      out_ready_i = 1'b1;
      tick();
    end

    // Fill and back-pressure
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(i, i);
      tick();
    end
    chk("fill_count", int'(count_o), 4);
    chk("fill_iready", int'(in_ready_o), 0);
    drive(5, 5);
    tick();
    tick();
    chk("held_count", int'(count_o), 4);
    chk("held_head", int'(s_o), 2);
    out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      accepted = in_valid_i && in_ready_o;
      tick();
      if (accepted) in_valid_i = 1'b0;
    end
    chk("fill_npops", pop_s.size(), 5);
    for (int k = 0; k < 5 && k < pop_s.size(); k++) begin
      chk("fill_pop_s", pop_s[k], 2 * (k + 1));
      chk("fill_pop_seq", pop_seq[k], k);
    end

    // Simultaneous push and pop at occupancy 2
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 15));
      tick();
    end
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 15));
      tick();
      chk("sim_count", int'(count_o), 2);
    end
    for (int k = 1; k < pop_seq.size(); k++)
      chk("sim_seq_step", pop_seq[k], (pop_seq[k-1] + 1) % 256);

    // Sequence wrap
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 15));
      tick();
    end
    in_valid_i = 1'b0;
    tick();
    tick();
    chk("wrap_npops", pop_seq.size(), 300);
    if (pop_seq.size() == 300) begin
      chk("wrap_seq255", pop_seq[255], 255);
      chk("wrap_seq256", pop_seq[256], 0);
      chk("wrap_seq_last", pop_seq[299], 43);
    end

    // Random traffic
    do_reset();
    for (int i = 0; i < 200; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      out_ready_i = 1'($urandom_range(0, 1));
      a_i         = WIDTH'($urandom_range(0, 15));
      b_i         = WIDTH'($urandom_range(0, 15));
      tick();
    end

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(i + 6, 7);
      tick();
    end
    in_valid_i = 1'b0;
    chk("mid_count_pre", int'(count_o), 3);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("mid_ovalid", int'(out_valid_o), 0);
    chk("mid_count", int'(count_o), 0);
    chk("mid_s", int'(s_o), 0);
    chk("mid_iready", int'(in_ready_o), 1);
    m_q.delete();
    m_seq = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1, 2);
    tick();
    in_valid_i = 1'b0;
    chk("mid_after_seq", int'(seq_o), 0);
    chk("mid_after_s", int'(s_o), 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
